// File: rtl/alu_pkg.sv
// Shared types for the iterative multiply/divide unit: funct3 op encoding,
// FSM states and small op-class decode helpers.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_t;

    function automatic logic is_div(input muldiv_op_t op);
        logic [2:0] b;
        b = op;
        return b[2];
    endfunction

    function automatic logic is_rem(input muldiv_op_t op);
        logic [2:0] b;
        b = op;
        return b[2] & b[1];
    endfunction

    // Multiplies that return the upper half of the double-width product.
    function automatic logic is_mulh(input muldiv_op_t op);
        logic [2:0] b;
        b = op;
        return !b[2] && (b[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/alu_muldiv_abs.sv
// Combinational conditional two's-complement negate; used both to take operand
// magnitudes and to restore the sign of the final result.
module alu_muldiv_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/alu_muldiv_iter.sv
// Iterative RISC-V M-extension unit: shift-add multiply, restoring divide, one bit
// per cycle. Define MULDIV_EARLY_OUT_EN to enable multiply/divide early exit.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  muldiv_op_t            op,
    input  logic [DATA_WIDTH-1:0] src1,
    input  logic [DATA_WIDTH-1:0] src2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
);

    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    muldiv_state_t  state_q;
    muldiv_op_t     op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic           neg_q;
    logic [W-1:0]   result_q;
    logic           out_valid_q;

    assign in_ready  = (state_q == S_IDLE) && !flush;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = (state_q != S_IDLE);

    // Request decode: operand signedness, magnitudes and special cases.
    logic         sign_a, sign_b, neg_in;
    logic [W-1:0] mag_a, mag_b;
    logic         div_zero, div_ovf, special;
    logic [W-1:0] special_res;

    assign sign_a = src1[W-1] && (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign sign_b = src2[W-1] && (op inside {OP_MULH, OP_DIV, OP_REM});
    assign neg_in = is_rem(op) ? sign_a : (sign_a ^ sign_b);

    alu_muldiv_abs #(.WIDTH(W)) u_abs_a (.val_i(src1), .neg_i(sign_a), .val_o(mag_a));
    alu_muldiv_abs #(.WIDTH(W)) u_abs_b (.val_i(src2), .neg_i(sign_b), .val_o(mag_b));

    assign div_zero = is_div(op) && (src2 == '0);
    assign div_ovf  = (op == OP_DIV || op == OP_REM) && (src1 == MIN_VAL) && (src2 == '1);

`ifdef MULDIV_EARLY_OUT_EN
    logic div_small;
    assign div_small = is_div(op) && (mag_b > mag_a);
    assign special   = div_zero || div_ovf || div_small;
`else
    assign special   = div_zero || div_ovf;
`endif

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = is_rem(op) ? src1 : '1;
        else if (div_ovf)
            special_res = is_rem(op) ? '0 : MIN_VAL;
        else
            special_res = is_rem(op) ? src1 : '0;
    end

    // One iteration: acc holds {remainder, dividend/quotient} for divide and the
    // running product for multiply, where opa is the left-shifting multiplicand.
    logic [W:0] rem_sh;
    always_comb begin
        acc_d  = acc_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        rem_sh = '0;
        if (is_div(op_q)) begin
            rem_sh = {acc_q[2*W-1:W], acc_q[W-1]};
            if (rem_sh < {1'b0, opa_q[W-1:0]})
                acc_d = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
            else
                acc_d = {rem_sh[W-1:0] - opa_q[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
            if (opb_q[0])
                acc_d = acc_q + opa_q;
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
        end
    end

    logic calc_last;
`ifdef MULDIV_EARLY_OUT_EN
    assign calc_last = (cnt_q == '0) || (!is_div(op_q) && (opb_d == '0));
`else
    assign calc_last = (cnt_q == '0);
`endif

    logic [2*W-1:0] fix_in, fix_out;
    logic [W-1:0]   fix_res;
    assign fix_in  = !is_div(op_q) ? acc_q
                   : {{W{1'b0}}, (is_rem(op_q) ? acc_q[2*W-1:W] : acc_q[W-1:0])};
    alu_muldiv_abs #(.WIDTH(2*W)) u_fix (.val_i(fix_in), .neg_i(neg_q), .val_o(fix_out));
    assign fix_res = is_mulh(op_q) ? fix_out[2*W-1:W] : fix_out[W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_MUL;
            cnt_q       <= '0;
            acc_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            neg_q       <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (flush && state_q != S_IDLE) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        op_q  <= op;
                        neg_q <= neg_in;
                        if (special) begin
                            result_q    <= special_res;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            acc_q   <= is_div(op) ? {{W{1'b0}}, mag_a} : '0;
                            opa_q   <= {{W{1'b0}}, (is_div(op) ? mag_b : mag_a)};
                            opb_q   <= is_div(op) ? '0 : mag_b;
                            cnt_q   <= CNT_W'(W - 1);
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (calc_last)
                        state_q <= S_FIX;
                end
                S_FIX: begin
                    result_q    <= fix_res;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Directed bench for alu_muldiv_iter: hand-computed results, latency bounds,
// backpressure, flush and mid-operation reset.
module tb_alu_muldiv_iter;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    muldiv_op_t   op = OP_MUL;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src2 = '0;
    logic         in_ready, out_valid, busy;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    alu_muldiv_iter #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .src1(src1), .src2(src2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start(input muldiv_op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        in_valid = 1'b1; op = o; src1 = a; src2 = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // lat > 0: exact latency (accepting edge counts as 1); lat == 0: bound only.
    task automatic do_op(input muldiv_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] e, input int lat, input string tag);
        int n;
        @(negedge clk);
        chk({tag, ".rdy"}, in_ready, 1);
        start(o, a, b);
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk({tag, ".vld"}, out_valid, 1);
        chk({tag, ".res"}, result, e);
        if (lat > 0) chk({tag, ".lat"}, n, lat);
        else         chk({tag, ".lat_le34"}, n <= 34, 1);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, ".drop"}, out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.result",    result,    0);
        chk("rst.busy",      busy,      0);
        chk("rst.in_ready",  in_ready,  1);
        @(negedge clk) rst_n = 1'b1;

        do_op(OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_neg");
        do_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh_min");
        do_op(OP_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulhu_min");
        do_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu_m1");
        do_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_max");
        do_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0,  "mulh_m1m1");
        do_op(OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 0,  "mul_shift");
        do_op(OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, "div_neg7");
        do_op(OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, "rem_neg7");
        do_op(OP_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div_negb");
        do_op(OP_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34, "rem_negb");
        do_op(OP_DIVU,   32'd100,       32'd7,         32'd14,        34, "divu_100");
        do_op(OP_REMU,   32'd100,       32'd7,         32'd2,         34, "remu_100");
        do_op(OP_DIVU,   32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 34, "divu_max");
        do_op(OP_REMU,   32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 34, "remu_max");
        do_op(OP_DIVU,   32'd3,         32'd7,         32'd0,         0,  "divu_small");
        do_op(OP_REM,    32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFD, 0,  "rem_small");
        do_op(OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "divu_z");
        do_op(OP_REM,    32'd5,         32'd0,         32'd5,         1,  "rem_z");
        do_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  "rem_ovf");
        do_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");

        // Backpressure: result and state hold while out_ready stays low.
        start(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp.vld", out_valid, 1);
            chk("bp.res", result, 32'hFFFF_FFFE);
            chk("bp.in_ready", in_ready, 0);
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("bp.release", busy, 0);

        // Flush mid-CALC: straight back to IDLE, no result ever appears.
        start(OP_DIVU, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush.busy", busy, 0);
        chk("flush.vld", out_valid, 0);
        flush = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        chk("flush.no_result", seen, 0);

        // Flush with a request in IDLE: the request is refused.
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = OP_DIVU; src1 = 32'd100; src2 = 32'd7;
        #1 chk("flush_idle.in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        chk("flush_idle.busy", busy, 0);
        flush = 1'b0; in_valid = 1'b0;

        // Reset mid-CALC clears outputs, including the previously held result.
        start(OP_MUL, 32'd3, 32'd5);
        repeat (5) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid.vld", out_valid, 0);
        chk("rst_mid.busy", busy, 0);
        chk("rst_mid.res", result, 0);
        @(negedge clk) rst_n = 1'b1;

        do_op(OP_MUL, 32'd3, 32'd5, 32'd15, 0, "mul_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
